// File: rtl/pipeline_pkg.sv
// Shared encodings for the 16-bit core: opcodes, hazard-controller FSM states and
// operand-forwarding selects used by Decode, Execute and the hazard controller.
package pipeline_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_OR     = 4'b0100;
  localparam logic [3:0] OP_XOR    = 4'b0101;
  localparam logic [3:0] OP_JUMP   = 4'b0110;
  localparam logic [3:0] OP_JUMPL  = 4'b0111;
  localparam logic [3:0] OP_JUMPG  = 4'b1000;
  localparam logic [3:0] OP_JUMPE  = 4'b1001;
  localparam logic [3:0] OP_JUMPNE = 4'b1010;
  localparam logic [3:0] OP_CMP    = 4'b1011;
  localparam logic [3:0] OP_LOAD   = 4'b1100;
  localparam logic [3:0] OP_STORE  = 4'b1101;
  localparam logic [3:0] OP_LDI    = 4'b1110;
  localparam logic [3:0] OP_MOV    = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Conditional jumps read the flags written by CMP.
  function automatic logic is_cond_jump(input logic [3:0] op);
    return (op >= OP_JUMPL) && (op <= OP_JUMPNE);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational register-index compare: forwarding selects per source plus
// load-use and CMP->conditional-jump hazard detects.
module hazard_fwd_unit
  import pipeline_pkg::*;
(
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [5:0] id_src1_idx,
  input  logic [5:0] id_src2_idx,
  input  logic       id_use_src1,
  input  logic       id_use_src2,
  input  logic [3:0] ex_opcode,
  input  logic [5:0] ex_dest_idx,
  input  logic       ex_we,
  input  logic [5:0] mem_dest_idx,
  input  logic       mem_we,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2,
  output logic       load_use,
  output logic       flag_hazard
);

  // A LOAD result does not exist in Execute yet, so it can only come from Mem.
  function automatic logic [1:0] pick_fwd(input logic use_src, input logic [5:0] src,
                                          input logic [3:0] ex_op, input logic [5:0] ex_dst,
                                          input logic ex_wr, input logic [5:0] mem_dst,
                                          input logic mem_wr);
    if (use_src && ex_wr && ex_dst == src && ex_op != OP_LOAD) return FWD_EX;
    if (use_src && mem_wr && mem_dst == src)                   return FWD_MEM;
    return FWD_RF;
  endfunction

  logic src1_hit_ex;
  logic src2_hit_ex;

  always_comb begin
    fwd_sel1    = pick_fwd(id_use_src1, id_src1_idx, ex_opcode, ex_dest_idx, ex_we,
                           mem_dest_idx, mem_we);
    fwd_sel2    = pick_fwd(id_use_src2, id_src2_idx, ex_opcode, ex_dest_idx, ex_we,
                           mem_dest_idx, mem_we);
    src1_hit_ex = id_use_src1 && (id_src1_idx == ex_dest_idx);
    src2_hit_ex = id_use_src2 && (id_src2_idx == ex_dest_idx);
    load_use    = id_valid && (ex_opcode == OP_LOAD) && ex_we && (src1_hit_ex || src2_hit_ex);
    flag_hazard = id_valid && (ex_opcode == OP_CMP) && is_cond_jump(id_opcode);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode->Execute->Mem sequencer: stalls, bubbles, jump flushes, memory freeze,
// forwarding selects, mem-wait timeout flag and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [5:0]       id_src1_idx,
  input  logic [5:0]       id_src2_idx,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [3:0]       ex_opcode,
  input  logic [5:0]       ex_dest_idx,
  input  logic             ex_we,
  input  logic [5:0]       mem_dest_idx,
  input  logic             mem_we,
  input  logic             ex_jump_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic             flush_if_id,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LIMIT     = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST      = TO_W'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic [TO_W-1:0] wait_cnt;

  logic [1:0] raw_sel1;
  logic [1:0] raw_sel2;
  logic       load_use;
  logic       flag_hazard;
  logic       wait_act;
  logic       flushing;
  logic       hazard_stall;

  hazard_fwd_unit u_fwd (
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_src1_idx  (id_src1_idx),
    .id_src2_idx  (id_src2_idx),
    .id_use_src1  (id_use_src1),
    .id_use_src2  (id_use_src2),
    .ex_opcode    (ex_opcode),
    .ex_dest_idx  (ex_dest_idx),
    .ex_we        (ex_we),
    .mem_dest_idx (mem_dest_idx),
    .mem_we       (mem_we),
    .fwd_sel1     (raw_sel1),
    .fwd_sel2     (raw_sel2),
    .load_use     (load_use),
    .flag_hazard  (flag_hazard)
  );

  // The cycle mem_busy drops still counts as a wait cycle; the pipeline releases a cycle later.
  always_comb begin
    wait_act     = mem_busy || (state == ST_MEMWAIT);
    flushing     = !wait_act && (ex_jump_taken || (state == ST_FLUSH));
    hazard_stall = !wait_act && !flushing && (load_use || flag_hazard);
    pc_stall     = 1'b0;
    id_stall     = 1'b0;
    ex_bubble    = 1'b0;
    flush_if_id  = 1'b0;
    fwd_sel1     = FWD_RF;
    fwd_sel2     = FWD_RF;
    if (!reset) begin
      pc_stall    = wait_act || hazard_stall;
      id_stall    = wait_act || hazard_stall;
      ex_bubble   = hazard_stall;
      flush_if_id = flushing;
      fwd_sel1    = hazard_stall ? FWD_RF : raw_sel1;
      fwd_sel2    = hazard_stall ? FWD_RF : raw_sel2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_RUN;
      flush_cnt       <= '0;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
      stall_count     <= '0;
    end else begin
      if (pc_stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);

      if (mem_busy) begin
        if (wait_cnt != TO_LIMIT) wait_cnt <= wait_cnt + TO_W'(1);
        if (wait_cnt >= TO_LAST) mem_timeout_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      // Leaving MEMWAIT drops any pending flush; Execute still holds the jump and re-resolves it.
      if (mem_busy) begin
        state     <= ST_MEMWAIT;
        flush_cnt <= '0;
      end else if (state == ST_MEMWAIT) begin
        state <= ST_RUN;
      end else if (ex_jump_taken) begin
        if (FLUSH_CYCLES > 1) begin
          state     <= ST_FLUSH;
          flush_cnt <= FLUSH_RELOAD;
        end else begin
          state <= ST_RUN;
        end
      end else if (state == ST_FLUSH) begin
        flush_cnt <= flush_cnt - FC_W'(1);
        if (flush_cnt <= FC_W'(1)) state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector table for the combinational hazard/forwarding decode, plus hand-written
// sequences for load-use recovery, jump flush, memory wait/timeout, saturation and reset.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [5:0] id_src1_idx;
  logic [5:0] id_src2_idx;
  logic       id_use_src1;
  logic       id_use_src2;
  logic [3:0] ex_opcode;
  logic [5:0] ex_dest_idx;
  logic       ex_we;
  logic [5:0] mem_dest_idx;
  logic       mem_we;
  logic       ex_jump_taken;
  logic       mem_busy;
  logic       pc_stall;
  logic       id_stall;
  logic       ex_bubble;
  logic       flush_if_id;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic       mem_timeout_err;
  logic [4:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_src1_idx     (id_src1_idx),
    .id_src2_idx     (id_src2_idx),
    .id_use_src1     (id_use_src1),
    .id_use_src2     (id_use_src2),
    .ex_opcode       (ex_opcode),
    .ex_dest_idx     (ex_dest_idx),
    .ex_we           (ex_we),
    .mem_dest_idx    (mem_dest_idx),
    .mem_we          (mem_we),
    .ex_jump_taken   (ex_jump_taken),
    .mem_busy        (mem_busy),
    .pc_stall        (pc_stall),
    .id_stall        (id_stall),
    .ex_bubble       (ex_bubble),
    .flush_if_id     (flush_if_id),
    .fwd_sel1        (fwd_sel1),
    .fwd_sel2        (fwd_sel2),
    .mem_timeout_err (mem_timeout_err),
    .stall_count     (stall_count)
  );

  // exp packs {pc_stall, id_stall, ex_bubble, flush_if_id, fwd_sel1, fwd_sel2}
  typedef struct {
    logic       id_valid;
    logic [3:0] id_op;
    logic [5:0] s1;
    logic [5:0] s2;
    logic       u1;
    logic       u2;
    logic [3:0] ex_op;
    logic [5:0] ex_dest;
    logic       ex_we;
    logic [5:0] mem_dest;
    logic       mem_we;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];
  int   applied = 0;
  int   errors  = 0;

  function automatic vec_t mk(input int idv, input logic [3:0] idop, input int s1, input int s2,
                              input int u1, input int u2, input logic [3:0] exop, input int exd,
                              input int exwe, input int md, input int mwe, input logic [7:0] exp);
    vec_t v;
    v.id_valid = 1'(idv);
    v.id_op    = idop;
    v.s1       = 6'(s1);
    v.s2       = 6'(s2);
    v.u1       = 1'(u1);
    v.u2       = 1'(u2);
    v.ex_op    = exop;
    v.ex_dest  = 6'(exd);
    v.ex_we    = 1'(exwe);
    v.mem_dest = 6'(md);
    v.mem_we   = 1'(mwe);
    v.exp      = exp;
    return v;
  endfunction

  function automatic logic [7:0] obs();
    return {pc_stall, id_stall, ex_bubble, flush_if_id, fwd_sel1, fwd_sel2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid      = v.id_valid;
    id_opcode     = v.id_op;
    id_src1_idx   = v.s1;
    id_src2_idx   = v.s2;
    id_use_src1   = v.u1;
    id_use_src2   = v.u2;
    ex_opcode     = v.ex_op;
    ex_dest_idx   = v.ex_dest;
    ex_we         = v.ex_we;
    mem_dest_idx  = v.mem_dest;
    mem_we        = v.mem_we;
    ex_jump_taken = 1'b0;
    mem_busy      = 1'b0;
  endtask

  task automatic idle();
    drive(mk(0, OP_NOP, 0, 0, 0, 0, OP_NOP, 0, 0, 0, 0, 8'h00));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(0, OP_NOP,    0, 0, 0, 0, OP_NOP,  0, 0, 0, 0, 8'b1110_0000 & 8'h00);
    vecs[1]  = mk(1, OP_ADD,    3, 4, 1, 1, OP_LOAD, 3, 1, 0, 0, 8'b1110_0000);
    vecs[2]  = mk(1, OP_ADD,    4, 3, 0, 1, OP_LOAD, 3, 1, 0, 0, 8'b1110_0000);
    vecs[3]  = mk(1, OP_ADD,    3, 4, 0, 1, OP_LOAD, 3, 1, 0, 0, 8'b0000_0000);
    vecs[4]  = mk(0, OP_ADD,    3, 3, 1, 1, OP_LOAD, 3, 1, 0, 0, 8'b0000_0000);
    vecs[5]  = mk(1, OP_SUB,    2, 5, 1, 1, OP_ADD,  5, 1, 5, 1, 8'b0000_0001);
    vecs[6]  = mk(1, OP_SUB,    2, 5, 1, 1, OP_ADD,  5, 0, 5, 1, 8'b0000_0010);
    vecs[7]  = mk(1, OP_AND,    0, 0, 1, 1, OP_ADD,  7, 1, 0, 1, 8'b0000_1010);
    vecs[8]  = mk(1, OP_JUMPE,  9, 0, 1, 0, OP_CMP,  0, 0, 9, 1, 8'b1110_0000);
    vecs[9]  = mk(1, OP_JUMP,   9, 0, 1, 0, OP_CMP,  0, 0, 9, 1, 8'b0000_1000);
    vecs[10] = mk(1, OP_JUMPL,  0, 0, 0, 0, OP_CMP,  0, 0, 0, 0, 8'b1110_0000);
    vecs[11] = mk(1, OP_JUMPNE, 0, 0, 0, 0, OP_CMP,  0, 0, 0, 0, 8'b1110_0000);
    vecs[12] = mk(1, OP_LOAD,   0, 0, 0, 0, OP_CMP,  0, 0, 0, 0, 8'b0000_0000);
    vecs[13] = mk(0, OP_JUMPNE, 0, 0, 0, 0, OP_CMP,  0, 0, 0, 0, 8'b0000_0000);
    vecs[14] = mk(1, OP_ADD,    3, 0, 1, 0, OP_LOAD, 3, 0, 0, 0, 8'b0000_0000);
    vecs[15] = mk(1, OP_ADD,    6, 6, 1, 0, OP_ADD,  6, 1, 6, 1, 8'b0000_0100);

    // Reset: outputs held at zero even with a load-use pattern on the inputs.
    reset = 1'b1;
    idle();
    tick();
    tick();
    drive(vecs[1]);
    sample();
    chk("reset_outs", 32'(obs()), 32'h0);
    chk("reset_err", 32'(mem_timeout_err), 32'h0);
    chk("reset_cnt", 32'(stall_count), 32'h0);
    tick();
    reset = 1'b0;
    idle();
    tick();

    // LOAD r3 in EX, ADD r3 in ID: one stall+bubble, then Mem forwarding.
    drive(vecs[1]);
    sample();
    chk("lu_stall", 32'(obs()), 32'(8'b1110_0000));
    tick();
    drive(mk(1, OP_ADD, 3, 4, 1, 1, OP_NOP, 0, 0, 3, 1, 8'h00));
    sample();
    chk("lu_fwd_mem", 32'(obs()), 32'(8'b0000_1000));
    chk("lu_cnt", 32'(stall_count), 32'd1);
    tick();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      sample();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      tick();
    end
    idle();
    sample();
    chk("table_cnt", 32'(stall_count), 32'd6);
    tick();

    // Taken jump with a load-use present: two flush cycles, no stall, then the stall.
    drive(vecs[1]);
    ex_jump_taken = 1'b1;
    sample();
    chk("jump_flush0", 32'(obs()), 32'(8'b0001_0000));
    tick();
    drive(vecs[1]);
    sample();
    chk("jump_flush1", 32'(obs()), 32'(8'b0001_0000));
    tick();
    drive(vecs[1]);
    sample();
    chk("jump_after", 32'(obs()), 32'(8'b1110_0000));
    tick();

    // Second jump during FLUSH reloads the counter.
    idle();
    ex_jump_taken = 1'b1;
    sample();
    chk("reload_a", 32'(obs()), 32'(8'b0001_0000));
    tick();
    sample();
    chk("reload_b", 32'(obs()), 32'(8'b0001_0000));
    tick();
    ex_jump_taken = 1'b0;
    sample();
    chk("reload_c", 32'(obs()), 32'(8'b0001_0000));
    tick();
    sample();
    chk("reload_run", 32'(obs()), 32'(8'b0000_0000));
    tick();

    // Memory busy 20 cycles: freeze, no bubble, no flush; error after wait cycle 15.
    for (int k = 1; k <= 20; k++) begin
      idle();
      mem_busy      = 1'b1;
      ex_jump_taken = (k == 5);
      sample();
      chk($sformatf("wait%0d_outs", k), 32'(obs()), 32'(8'b1100_0000));
      chk($sformatf("wait%0d_err", k), 32'(mem_timeout_err), 32'(k >= 16));
      tick();
    end
    idle();
    sample();
    chk("wait_exit_outs", 32'(obs()), 32'(8'b1100_0000));
    tick();
    sample();
    chk("wait_run_outs", 32'(obs()), 32'(8'b0000_0000));
    chk("wait_err_sticky", 32'(mem_timeout_err), 32'h1);
    chk("wait_cnt", 32'(stall_count), 32'd28);
    tick();

    // Push the 5-bit counter past its top: 28 + 7 stalls must stop at 31.
    for (int k = 0; k < 6; k++) begin
      mem_busy = 1'b1;
      tick();
    end
    mem_busy = 1'b0;
    tick();
    sample();
    chk("cnt_saturate", 32'(stall_count), 32'd31);
    tick();

    // Reset in the middle of a flush.
    idle();
    ex_jump_taken = 1'b1;
    tick();
    ex_jump_taken = 1'b0;
    reset = 1'b1;
    sample();
    chk("rst_flush_during", 32'(obs()), 32'h0);
    tick();
    reset = 1'b0;
    sample();
    chk("rst_flush_outs", 32'(obs()), 32'h0);
    chk("rst_flush_err", 32'(mem_timeout_err), 32'h0);
    chk("rst_flush_cnt", 32'(stall_count), 32'h0);
    tick();

    // Reset in the middle of a memory wait.
    mem_busy = 1'b1;
    tick();
    tick();
    tick();
    mem_busy = 1'b0;
    reset = 1'b1;
    sample();
    chk("rst_wait_during", 32'(obs()), 32'h0);
    tick();
    reset = 1'b0;
    sample();
    chk("rst_wait_outs", 32'(obs()), 32'h0);
    chk("rst_wait_cnt", 32'(stall_count), 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
